// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Control FSM that steps the softcore's program counter. It fetches the
//   instruction at i_PC from program memory over a req/ack handshake, decodes
//   it, pulses the ProgramCounter load/increment controls, and hands non-branch
//   instructions to the execute unit.
//
// Ports
//   i_clk, i_rst_n            clock (rising edge), asynchronous active-low reset
//   i_start                   begin execution (only looked at in IDLE)
//   i_PC                      current PC from ProgramCounter
//   o_incPC/o_loadPC/o_PCVal  ProgramCounter controls (single-cycle pulses)
//   o_mem_req/o_mem_addr      program memory read request / address
//   i_mem_ack/i_mem_data      read data valid / read data
//   i_zero                    zero flag used by JZ
//   o_instr                   instruction register
//   o_exec_valid/i_exec_ready execute-unit handshake
//   o_busy/o_halted/o_fault   status (FETCH/DECODE/EXEC, HALT, FAULT)
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int         ADDR_W  = 12,
    parameter int         INSTR_W = 16,
    parameter int         TIMEOUT = 255,
    parameter logic [3:0] OP_JMP  = 4'h1,
    parameter logic [3:0] OP_JZ   = 4'h2,
    parameter logic [3:0] OP_HALT = 4'hF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [ADDR_W-1:0]  i_PC,
    output logic               o_incPC,
    output logic               o_loadPC,
    output logic [ADDR_W-1:0]  o_PCVal,
    output logic               o_mem_req,
    output logic [ADDR_W-1:0]  o_mem_addr,
    input  logic               i_mem_ack,
    input  logic [INSTR_W-1:0] i_mem_data,
    input  logic               i_zero,
    output logic [INSTR_W-1:0] o_instr,
    output logic               o_exec_valid,
    input  logic               i_exec_ready,
    output logic               o_busy,
    output logic               o_halted,
    output logic               o_fault
);

    // Counter only ever needs to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT,
        S_FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic [3:0]         opcode;
    logic [ADDR_W-1:0]  operand;

    assign opcode  = instr_q[INSTR_W-1 -: 4];
    assign operand = instr_q[ADDR_W-1:0];
    assign o_instr = instr_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        cnt_d        = '0;
        o_incPC      = 1'b0;
        o_loadPC     = 1'b0;
        o_PCVal      = '0;
        o_mem_req    = 1'b0;
        o_mem_addr   = '0;
        o_exec_valid = 1'b0;
        o_busy       = 1'b0;
        o_halted     = 1'b0;
        o_fault      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                o_busy     = 1'b1;
                o_mem_req  = 1'b1;
                o_mem_addr = i_PC;
                // An ack in the last allowed cycle still counts as a fetch.
                if (i_mem_ack) begin
                    instr_d = i_mem_data;
                    state_d = S_DECODE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DECODE: begin
                o_busy = 1'b1;
                if (opcode == OP_JMP) begin
                    o_loadPC = 1'b1;
                    o_PCVal  = operand;
                    state_d  = S_FETCH;
                end else if (opcode == OP_JZ) begin
                    if (i_zero) begin
                        o_loadPC = 1'b1;
                        o_PCVal  = operand;
                    end else begin
                        o_incPC = 1'b1;
                    end
                    state_d = S_FETCH;
                end else if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    // PC advances now so the following fetch is already lined up.
                    o_incPC = 1'b1;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                o_busy       = 1'b1;
                o_exec_valid = 1'b1;
                if (i_exec_ready) begin
                    state_d = S_FETCH;
                end
            end

            S_HALT: begin
                o_halted = 1'b1;
            end

            S_FAULT: begin
                o_fault = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Self-checking bench for fetch_sequencer. A small ProgramCounter model
//   reacts to the sequencer's PC pulses; the reference expectations (fetch
//   address, PC pulse kind, handshake lengths) come from the instruction set
//   semantics tracked as a plain expected-PC value.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam int ADDR_W  = 12;
    localparam int INSTR_W = 16;
    localparam int TO      = 8;

    logic               i_clk = 1'b0;
    logic               i_rst_n;
    logic               i_start;
    logic [ADDR_W-1:0]  i_PC;
    logic               o_incPC;
    logic               o_loadPC;
    logic [ADDR_W-1:0]  o_PCVal;
    logic               o_mem_req;
    logic [ADDR_W-1:0]  o_mem_addr;
    logic               i_mem_ack;
    logic [INSTR_W-1:0] i_mem_data;
    logic               i_zero;
    logic [INSTR_W-1:0] o_instr;
    logic               o_exec_valid;
    logic               i_exec_ready;
    logic               o_busy;
    logic               o_halted;
    logic               o_fault;

    int checks   = 0;
    int failures = 0;

    fetch_sequencer #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W),
        .TIMEOUT(TO),
        .OP_JMP (4'h1),
        .OP_JZ  (4'h2),
        .OP_HALT(4'hF)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_PC        (i_PC),
        .o_incPC     (o_incPC),
        .o_loadPC    (o_loadPC),
        .o_PCVal     (o_PCVal),
        .o_mem_req   (o_mem_req),
        .o_mem_addr  (o_mem_addr),
        .i_mem_ack   (i_mem_ack),
        .i_mem_data  (i_mem_data),
        .i_zero      (i_zero),
        .o_instr     (o_instr),
        .o_exec_valid(o_exec_valid),
        .i_exec_ready(i_exec_ready),
        .o_busy      (o_busy),
        .o_halted    (o_halted),
        .o_fault     (o_fault)
    );

    always #5 i_clk = ~i_clk;

    // ProgramCounter stand-in driven by the sequencer's controls.
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      i_PC <= '0;
        else if (o_loadPC) i_PC <= o_PCVal;
        else if (o_incPC)  i_PC <= i_PC + 12'd1;
    end

    logic [46:0] all_outs;
    assign all_outs = {o_incPC, o_loadPC, o_PCVal, o_mem_req, o_mem_addr, o_instr,
                       o_exec_valid, o_busy, o_halted, o_fault};

    // Stimulus helper only: reset, then a one-cycle start pulse; returns at
    // the negedge of the first FETCH cycle.
    task automatic reset_and_start();
        i_rst_n = 1'b0; i_start = 1'b0; i_mem_ack = 1'b0; i_mem_data = '0;
        i_zero = 1'b0; i_exec_ready = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_start = 1'b1; i_mem_ack = 1'b1; i_mem_data = 16'($urandom);
            i_zero = 1'b1; i_exec_ready = 1'b1;
            @(negedge i_clk); #1;
            checks++;
            if (all_outs !== '0) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d got=%h want=0", k, all_outs);
            end
        end
        i_start = 1'b0; i_mem_ack = 1'b0; i_zero = 1'b0; i_exec_ready = 1'b0;
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        #1;
        checks++;
        if (o_mem_req !== 1'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_without_start req=%b busy=%b want 0 0", o_mem_req, o_busy);
        end
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0; #1;
        checks++;
        if (o_mem_req !== 1'b1 || o_mem_addr !== 12'h000 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL start_fetch req=%b addr=%h busy=%b want 1 000 1", o_mem_req, o_mem_addr, o_busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_sequential();
        reset_and_start();
        i_mem_ack = 1'b1; i_mem_data = 16'h3005; #1;
        checks++;
        if (o_mem_req !== 1'b1 || o_mem_addr !== 12'h000) begin
            failures++;
            $display("FAIL seq_fetch req=%b addr=%h want 1 000", o_mem_req, o_mem_addr);
        end
        @(negedge i_clk);
        i_mem_ack = 1'b0; i_mem_data = 16'hDEAD; #1;
        checks++;
        if ({o_incPC, o_loadPC, o_PCVal, o_instr} !== {1'b1, 1'b0, 12'h000, 16'h3005}) begin
            failures++;
            $display("FAIL seq_decode inc=%b load=%b val=%h instr=%h want 1 0 000 3005",
                     o_incPC, o_loadPC, o_PCVal, o_instr);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            i_exec_ready = (k == 2); #1;
            checks++;
            if (o_exec_valid !== 1'b1 || o_incPC !== 1'b0 || o_instr !== 16'h3005) begin
                failures++;
                $display("FAIL seq_exec cycle=%0d valid=%b inc=%b instr=%h want 1 0 3005",
                         k, o_exec_valid, o_incPC, o_instr);
            end
        end
        @(negedge i_clk);
        i_exec_ready = 1'b0; #1;
        checks++;
        if (o_mem_req !== 1'b1 || o_mem_addr !== 12'h001 || o_exec_valid !== 1'b0) begin
            failures++;
            $display("FAIL seq_next_fetch req=%b addr=%h valid=%b want 1 001 0",
                     o_mem_req, o_mem_addr, o_exec_valid);
        end
        $display("test_sequential done");
    endtask

    task automatic test_branches();
        reset_and_start();
        // JMP 0x105
        i_mem_ack = 1'b1; i_mem_data = 16'h1105;
        @(negedge i_clk);
        i_mem_ack = 1'b0; #1;
        checks++;
        if ({o_loadPC, o_incPC, o_PCVal} !== {1'b1, 1'b0, 12'h105}) begin
            failures++;
            $display("FAIL jmp_decode load=%b inc=%b val=%h want 1 0 105", o_loadPC, o_incPC, o_PCVal);
        end
        @(negedge i_clk); #1;
        checks++;
        if (o_mem_req !== 1'b1 || o_mem_addr !== 12'h105) begin
            failures++;
            $display("FAIL jmp_target req=%b addr=%h want 1 105", o_mem_req, o_mem_addr);
        end
        // JZ not taken
        i_mem_ack = 1'b1; i_mem_data = 16'h2020;
        @(negedge i_clk);
        i_mem_ack = 1'b0; i_zero = 1'b0; #1;
        checks++;
        if ({o_loadPC, o_incPC, o_PCVal} !== {1'b0, 1'b1, 12'h000}) begin
            failures++;
            $display("FAIL jz_not_taken load=%b inc=%b val=%h want 0 1 000", o_loadPC, o_incPC, o_PCVal);
        end
        @(negedge i_clk); #1;
        checks++;
        if (o_mem_addr !== 12'h106) begin
            failures++;
            $display("FAIL jz_fallthrough addr=%h want 106", o_mem_addr);
        end
        // JZ taken
        i_mem_ack = 1'b1; i_mem_data = 16'h2020;
        @(negedge i_clk);
        i_mem_ack = 1'b0; i_zero = 1'b1; #1;
        checks++;
        if ({o_loadPC, o_incPC, o_PCVal} !== {1'b1, 1'b0, 12'h020}) begin
            failures++;
            $display("FAIL jz_taken load=%b inc=%b val=%h want 1 0 020", o_loadPC, o_incPC, o_PCVal);
        end
        @(negedge i_clk);
        i_zero = 1'b0; #1;
        checks++;
        if (o_mem_addr !== 12'h020) begin
            failures++;
            $display("FAIL jz_target addr=%h want 020", o_mem_addr);
        end
        $display("test_branches done");
    endtask

    task automatic test_wait_states();
        int req_cycles = 0;
        reset_and_start();
        for (int k = 0; k <= 5; k++) begin
            i_mem_ack  = (k == 5);
            i_mem_data = (k == 5) ? 16'h4ABC : 16'($urandom);
            #1;
            if (o_mem_req === 1'b1) req_cycles++;
            checks++;
            if (o_mem_addr !== 12'h000) begin
                failures++;
                $display("FAIL wait_addr_stable cycle=%0d addr=%h want 000", k, o_mem_addr);
            end
            @(negedge i_clk);
        end
        i_mem_ack = 1'b0; #1;
        checks++;
        if (req_cycles != 6 || o_mem_req !== 1'b0 || o_instr !== 16'h4ABC) begin
            failures++;
            $display("FAIL wait_capture req_cycles=%0d req=%b instr=%h want 6 0 4abc",
                     req_cycles, o_mem_req, o_instr);
        end
        $display("test_wait_states done");
    endtask

    task automatic test_timeout();
        reset_and_start();
        for (int k = 0; k < TO; k++) begin
            #1;
            checks++;
            if (o_mem_req !== 1'b1 || o_fault !== 1'b0) begin
                failures++;
                $display("FAIL timeout_fetch cycle=%0d req=%b fault=%b want 1 0", k, o_mem_req, o_fault);
            end
            @(negedge i_clk);
        end
        for (int k = 0; k < 4; k++) begin
            i_start = k[0]; i_mem_ack = k[1];
            #1;
            checks++;
            if (o_fault !== 1'b1 || o_mem_req !== 1'b0 || o_busy !== 1'b0 || o_incPC !== 1'b0) begin
                failures++;
                $display("FAIL timeout_fault cycle=%0d fault=%b req=%b busy=%b inc=%b want 1 0 0 0",
                         k, o_fault, o_mem_req, o_busy, o_incPC);
            end
            @(negedge i_clk);
        end
        // Ack arriving in the last allowed cycle still completes the fetch.
        reset_and_start();
        repeat (TO - 1) @(negedge i_clk);
        i_mem_ack = 1'b1; i_mem_data = 16'h3777;
        @(negedge i_clk);
        i_mem_ack = 1'b0; #1;
        checks++;
        if (o_fault !== 1'b0 || o_incPC !== 1'b1 || o_instr !== 16'h3777) begin
            failures++;
            $display("FAIL timeout_late_ack fault=%b inc=%b instr=%h want 0 1 3777", o_fault, o_incPC, o_instr);
        end
        $display("test_timeout done");
    endtask

    task automatic test_halt_and_reset();
        reset_and_start();
        i_mem_ack = 1'b1; i_mem_data = 16'hF000;
        @(negedge i_clk);
        i_mem_ack = 1'b0; #1;
        checks++;
        if (o_incPC !== 1'b0 || o_loadPC !== 1'b0) begin
            failures++;
            $display("FAIL halt_decode inc=%b load=%b want 0 0", o_incPC, o_loadPC);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            i_start = 1'b1; #1;
            checks++;
            if (o_halted !== 1'b1 || o_mem_req !== 1'b0 || o_busy !== 1'b0 || i_PC !== 12'h000) begin
                failures++;
                $display("FAIL halt_sticky cycle=%0d halted=%b req=%b busy=%b pc=%h want 1 0 0 000",
                         k, o_halted, o_mem_req, o_busy, i_PC);
            end
        end
        i_start = 1'b0;
        // Reset asserted while the execute unit holds the instruction.
        reset_and_start();
        i_mem_ack = 1'b1; i_mem_data = 16'h3123;
        @(negedge i_clk);
        i_mem_ack = 1'b0;
        @(negedge i_clk); #1;
        checks++;
        if (o_exec_valid !== 1'b1) begin
            failures++;
            $display("FAIL midexec_valid got=%b want 1", o_exec_valid);
        end
        #1 i_rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs !== '0) begin
            failures++;
            $display("FAIL midexec_reset outs=%h want 0", all_outs);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        $display("test_halt_and_reset done");
    endtask

    task automatic test_random_program();
        logic [11:0] exp_pc;
        logic [11:0] exp_next;
        logic [15:0] instr;
        logic [3:0]  op;
        logic        exp_load, exp_inc, branch;
        logic [11:0] exp_val;
        int          wt, rd, sel;
        logic        z;
        reset_and_start();
        exp_pc = 12'h000;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 2)      op = 4'h1;
            else if (sel < 4) op = 4'h2;
            else if (sel == 4) op = 4'h0;
            else              op = 4'($urandom_range(3, 14));
            instr = {op, 12'($urandom)};
            wt = $urandom_range(0, 3);
            rd = $urandom_range(0, 3);
            z  = 1'($urandom_range(0, 1));

            for (int k = 0; k <= wt; k++) begin
                i_mem_ack  = (k == wt);
                i_mem_data = (k == wt) ? instr : 16'($urandom);
                #1;
                checks++;
                if (o_mem_req !== 1'b1 || o_mem_addr !== exp_pc) begin
                    failures++;
                    $display("FAIL rand_fetch n=%0d req=%b addr=%h want 1 %h", n, o_mem_req, o_mem_addr, exp_pc);
                end
                @(negedge i_clk);
            end
            i_mem_ack = 1'b0;
            i_zero = z;
            #1;
            branch  = (op == 4'h1) || (op == 4'h2 && z);
            exp_load = branch;
            exp_inc  = !branch;
            exp_val  = branch ? instr[11:0] : 12'h000;
            exp_next = branch ? instr[11:0] : exp_pc + 12'd1;
            checks++;
            if ({o_loadPC, o_incPC, o_PCVal, o_instr} !== {exp_load, exp_inc, exp_val, instr}) begin
                failures++;
                $display("FAIL rand_decode n=%0d instr=%h load=%b inc=%b val=%h want %b %b %h",
                         n, o_instr, o_loadPC, o_incPC, o_PCVal, exp_load, exp_inc, exp_val);
            end
            @(negedge i_clk);
            i_zero = 1'b0;
            if (op != 4'h1 && op != 4'h2) begin
                for (int k = 0; k <= rd; k++) begin
                    i_exec_ready = (k == rd);
                    #1;
                    checks++;
                    if (o_exec_valid !== 1'b1 || o_instr !== instr || o_mem_req !== 1'b0) begin
                        failures++;
                        $display("FAIL rand_exec n=%0d valid=%b instr=%h req=%b want 1 %h 0",
                                 n, o_exec_valid, o_instr, o_mem_req, instr);
                    end
                    @(negedge i_clk);
                end
                i_exec_ready = 1'b0;
            end
            exp_pc = exp_next;
        end
        $display("test_random_program done");
    endtask

    initial begin
        i_rst_n = 1'b0; i_start = 1'b0; i_mem_ack = 1'b0; i_mem_data = '0;
        i_zero = 1'b0; i_exec_ready = 1'b0;
        @(negedge i_clk);
        test_reset();
        test_sequential();
        test_branches();
        test_wait_states();
        test_timeout();
        test_halt_and_reset();
        test_random_program();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
